// File: rtl/control_ceas.sv
// Alarm-clock control core: 24 h timekeeping, time/alarm set-mode FSM, alarm compare and ring timeout.
// Optional snooze on short press of button 3 while ringing is built when CONTROL_SNOOZE_EN is defined.
module control_ceas #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       scurt_1,
    input  logic       scurt_2,
    input  logic       scurt_3,
    input  logic       lung_1,
    input  logic       lung_2,
    input  logic       lung_3,
    output logic [4:0] ore,
    output logic [5:0] minute,
    output logic [5:0] secunde,
    output logic [4:0] al_ore,
    output logic [5:0] al_min,
    output logic       al_en,
    output logic       suna,
    output logic [2:0] mod
);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        SET_ORA    = 3'd1,
        SET_MIN    = 3'd2,
        SET_AL_ORA = 3'd3,
        SET_AL_MIN = 3'd4
    } mode_t;

    localparam logic [7:0] RING_LIM = 8'(RING_SEC);

    mode_t      mod_q, mod_d;
    logic [4:0] ore_q, ore_d, alOre_q, alOre_d;
    logic [5:0] min_q, min_d, sec_q, sec_d, alMin_q, alMin_d;
    logic       alEn_q, alEn_d, suna_q, suna_d;
    logic [7:0] ringCnt_q, ringCnt_d;
    logic       countEn, alarmHit;
    logic [4:0] tOre;
    logic [5:0] tMin, tSec;

`ifdef CONTROL_SNOOZE_EN
    logic       snzValid_q, snzValid_d, snzHit;
    logic [4:0] snzOre_q, snzOre_d;
    logic [5:0] snzMin_q, snzMin_d;
    logic [6:0] snzMinSum;
`endif

    // Out-of-range parameters leave this empty block elaborated as a visible marker.
    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59 || RING_SEC < 1 || RING_SEC > 255) begin : g_param_out_of_range
    end

    function automatic logic [5:0] incWrap(input logic [5:0] v, input logic [5:0] top);
        return (v == top) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] decWrap(input logic [5:0] v, input logic [5:0] top);
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    always_comb begin
        mod_d     = mod_q;
        ore_d     = ore_q;
        min_d     = min_q;
        sec_d     = sec_q;
        alOre_d   = alOre_q;
        alMin_d   = alMin_q;
        alEn_d    = alEn_q;
        suna_d    = suna_q;
        ringCnt_d = ringCnt_q;
`ifdef CONTROL_SNOOZE_EN
        snzValid_d = snzValid_q;
        snzOre_d   = snzOre_q;
        snzMin_d   = snzMin_q;
        snzMinSum  = {1'b0, min_q} + 7'(SNOOZE_MIN);
`endif

        // Entering set mode from RUN freezes the clock for that cycle.
        countEn = tick_1s && (mod_q == RUN || mod_q == SET_AL_ORA || mod_q == SET_AL_MIN)
                  && !(lung_1 && mod_q == RUN);
        tOre = ore_q;
        tMin = min_q;
        tSec = sec_q;
        if (countEn) begin
            if (sec_q == 6'd59) begin
                tSec = 6'd0;
                if (min_q == 6'd59) begin
                    tMin = 6'd0;
                    tOre = (ore_q == 5'd23) ? 5'd0 : ore_q + 5'd1;
                end else begin
                    tMin = min_q + 6'd1;
                end
            end else begin
                tSec = sec_q + 6'd1;
            end
        end
        ore_d = tOre;
        min_d = tMin;
        sec_d = tSec;

        if (suna_q && tick_1s) begin
            ringCnt_d = ringCnt_q + 8'd1;
            if (ringCnt_q + 8'd1 == RING_LIM) suna_d = 1'b0;
        end

        if (lung_1) begin
            if (mod_q == RUN) begin
                mod_d = SET_ORA;
                sec_d = 6'd0;
            end else begin
                mod_d = RUN;
            end
        end else if (lung_3) begin
            suna_d = 1'b0;
`ifdef CONTROL_SNOOZE_EN
            snzValid_d = 1'b0;
`endif
        end else if (scurt_1) begin
            case (mod_q)
                SET_ORA:    mod_d = SET_MIN;
                SET_MIN:    mod_d = SET_AL_ORA;
                SET_AL_ORA: mod_d = SET_AL_MIN;
                SET_AL_MIN: mod_d = SET_ORA;
                default:    mod_d = mod_q;
            endcase
        end else if (scurt_2) begin
            case (mod_q)
                SET_ORA:    ore_d   = 5'(incWrap({1'b0, ore_q}, 6'd23));
                SET_MIN:    min_d   = incWrap(min_q, 6'd59);
                SET_AL_ORA: alOre_d = 5'(incWrap({1'b0, alOre_q}, 6'd23));
                SET_AL_MIN: alMin_d = incWrap(alMin_q, 6'd59);
                default:    ;
            endcase
        end else if (scurt_3) begin
            case (mod_q)
                SET_ORA:    ore_d   = 5'(decWrap({1'b0, ore_q}, 6'd23));
                SET_MIN:    min_d   = decWrap(min_q, 6'd59);
                SET_AL_ORA: alOre_d = 5'(decWrap({1'b0, alOre_q}, 6'd23));
                SET_AL_MIN: alMin_d = decWrap(alMin_q, 6'd59);
                default: begin
`ifdef CONTROL_SNOOZE_EN
                    if (suna_q) begin
                        suna_d     = 1'b0;
                        snzValid_d = 1'b1;
                        if (snzMinSum >= 7'd60) begin
                            snzMin_d = 6'(snzMinSum - 7'd60);
                            snzOre_d = (ore_q == 5'd23) ? 5'd0 : ore_q + 5'd1;
                        end else begin
                            snzMin_d = snzMinSum[5:0];
                            snzOre_d = ore_q;
                        end
                    end
`endif
                end
            endcase
        end

        // A trigger overrides a same-cycle stop request.
        alarmHit = countEn && alEn_q && tOre == alOre_q && tMin == alMin_q && tSec == 6'd0;
`ifdef CONTROL_SNOOZE_EN
        snzHit = countEn && snzValid_q && tOre == snzOre_q && tMin == snzMin_q && tSec == 6'd0;
        if (snzHit) snzValid_d = 1'b0;
        if (alarmHit || snzHit) begin
`else
        if (alarmHit) begin
`endif
            suna_d    = 1'b1;
            ringCnt_d = 8'd0;
        end

        if (lung_2) begin
            alEn_d = ~alEn_q;
            if (alEn_q) begin
                suna_d = 1'b0;
`ifdef CONTROL_SNOOZE_EN
                snzValid_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mod_q     <= RUN;
            ore_q     <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            alOre_q   <= '0;
            alMin_q   <= '0;
            alEn_q    <= 1'b0;
            suna_q    <= 1'b0;
            ringCnt_q <= '0;
`ifdef CONTROL_SNOOZE_EN
            snzValid_q <= 1'b0;
            snzOre_q   <= '0;
            snzMin_q   <= '0;
`endif
        end else begin
            mod_q     <= mod_d;
            ore_q     <= ore_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            alOre_q   <= alOre_d;
            alMin_q   <= alMin_d;
            alEn_q    <= alEn_d;
            suna_q    <= suna_d;
            ringCnt_q <= ringCnt_d;
`ifdef CONTROL_SNOOZE_EN
            snzValid_q <= snzValid_d;
            snzOre_q   <= snzOre_d;
            snzMin_q   <= snzMin_d;
`endif
        end
    end

    assign ore     = ore_q;
    assign minute  = min_q;
    assign secunde = sec_q;
    assign al_ore  = alOre_q;
    assign al_min  = alMin_q;
    assign al_en   = alEn_q;
    assign suna    = suna_q;
    assign mod     = mod_q;

endmodule

// File: tb/tb_control_ceas.sv
// Directed testbench for control_ceas; the snooze scenario is included when CONTROL_SNOOZE_EN is defined.
module tb_control_ceas;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1s = 1'b0;
    logic       scurt_1 = 1'b0, scurt_2 = 1'b0, scurt_3 = 1'b0;
    logic       lung_1 = 1'b0, lung_2 = 1'b0, lung_3 = 1'b0;
    logic [4:0] ore, al_ore;
    logic [5:0] minute, secunde, al_min;
    logic       al_en, suna;
    logic [2:0] mod;

    int vectorCount = 0;
    int missCount   = 0;

    localparam logic [6:0] TICK = 7'b1000000;
    localparam logic [6:0] L1   = 7'b0100000;
    localparam logic [6:0] L2   = 7'b0010000;
    localparam logic [6:0] L3   = 7'b0001000;
    localparam logic [6:0] S1   = 7'b0000100;
    localparam logic [6:0] S2   = 7'b0000010;
    localparam logic [6:0] S3   = 7'b0000001;

    control_ceas #(.RING_SEC(60), .SNOOZE_MIN(5)) dut (
        .clock(clock), .reset(reset), .tick_1s(tick_1s),
        .scurt_1(scurt_1), .scurt_2(scurt_2), .scurt_3(scurt_3),
        .lung_1(lung_1), .lung_2(lung_2), .lung_3(lung_3),
        .ore(ore), .minute(minute), .secunde(secunde),
        .al_ore(al_ore), .al_min(al_min), .al_en(al_en),
        .suna(suna), .mod(mod)
    );

    always #5 clock = ~clock;

    // Holds the selected inputs high for n consecutive clocks, returning on a falling edge.
    task automatic applyStimulus(input logic [6:0] v, input int n);
        @(negedge clock);
        {tick_1s, lung_1, lung_2, lung_3, scurt_1, scurt_2, scurt_3} = v;
        repeat (n) @(negedge clock);
        {tick_1s, lung_1, lung_2, lung_3, scurt_1, scurt_2, scurt_3} = 7'b0;
    endtask

    task automatic checkOutput(input string tag, input int got, input int exp);
        vectorCount++;
        if (got != exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkTime(input string tag, input int h, input int m, input int s);
        checkOutput({tag, " ore"}, int'(ore), h);
        checkOutput({tag, " minute"}, int'(minute), m);
        checkOutput({tag, " secunde"}, int'(secunde), s);
    endtask

    initial begin
        #12;
        checkTime("reset", 0, 0, 0);
        checkOutput("reset mod", int'(mod), 0);
        checkOutput("reset suna", int'(suna), 0);
        checkOutput("reset al_en", int'(al_en), 0);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus(TICK, 3661);
        checkTime("3661 ticks", 1, 1, 1);
        checkOutput("3661 ticks mod", int'(mod), 0);
        checkOutput("3661 ticks suna", int'(suna), 0);

        applyStimulus(L1, 1);
        checkOutput("enter set mod", int'(mod), 1);
        checkOutput("enter set secunde", int'(secunde), 0);
        applyStimulus(S3, 1);
        checkOutput("dec ore 1", int'(ore), 0);
        applyStimulus(S3, 1);
        checkOutput("dec ore wrap", int'(ore), 23);
        applyStimulus(S1, 1);
        checkOutput("field cycle 2", int'(mod), 2);
        applyStimulus(S3, 2);
        checkOutput("dec min wrap", int'(minute), 59);
        applyStimulus(S1, 1);
        checkOutput("field cycle 3", int'(mod), 3);
        applyStimulus(S1, 1);
        checkOutput("field cycle 4", int'(mod), 4);
        applyStimulus(S1, 1);
        checkOutput("field cycle 1", int'(mod), 1);
        applyStimulus(TICK, 5);
        checkTime("paused in SET_ORA", 23, 59, 0);
        applyStimulus(L1, 1);
        checkOutput("back to run", int'(mod), 0);
        applyStimulus(TICK, 59);
        checkTime("preload", 23, 59, 59);
        applyStimulus(TICK, 1);
        checkTime("day wrap", 0, 0, 0);

        applyStimulus(L1, 1);
        applyStimulus(S1, 1);
        applyStimulus(S3, 1);
        checkOutput("min edit dec", int'(minute), 59);
        applyStimulus(S2, 1);
        checkOutput("min edit inc wrap", int'(minute), 0);
        checkOutput("min edit no carry", int'(ore), 0);
        applyStimulus(L1, 1);
        applyStimulus(S2, 1);
        checkOutput("run ignores inc", int'(minute), 0);
        applyStimulus(S1, 1);
        checkOutput("run ignores field", int'(mod), 0);

        applyStimulus(L1, 1);
        applyStimulus(S2, 7);
        applyStimulus(S1, 1);
        applyStimulus(S2, 29);
        applyStimulus(S1, 1);
        applyStimulus(S2, 7);
        applyStimulus(S1, 1);
        applyStimulus(S2, 30);
        checkOutput("al_ore set", int'(al_ore), 7);
        checkOutput("al_min set", int'(al_min), 30);
        applyStimulus(L1, 1);
        applyStimulus(L2, 1);
        checkOutput("arm al_en", int'(al_en), 1);
        applyStimulus(TICK, 59);
        checkTime("pre alarm", 7, 29, 59);
        checkOutput("pre alarm suna", int'(suna), 0);
        applyStimulus(TICK, 1);
        checkOutput("alarm trigger", int'(suna), 1);
        applyStimulus(TICK, 59);
        checkOutput("ring 59", int'(suna), 1);
        applyStimulus(TICK, 1);
        checkOutput("ring timeout", int'(suna), 0);
        checkOutput("timeout keeps al_en", int'(al_en), 1);

        applyStimulus(L1, 1);
        applyStimulus(S1, 3);
        checkOutput("to SET_AL_MIN", int'(mod), 4);
        applyStimulus(S2, 2);
        applyStimulus(L1, 1);
        applyStimulus(TICK, 60);
        checkTime("second alarm", 7, 32, 0);
        checkOutput("second alarm suna", int'(suna), 1);
        applyStimulus(TICK, 5);
        applyStimulus(L3, 1);
        checkOutput("lung_3 stop", int'(suna), 0);
        checkOutput("lung_3 keeps al_en", int'(al_en), 1);

        applyStimulus(L1, 1);
        applyStimulus(S1, 3);
        applyStimulus(S2, 1);
        applyStimulus(L1, 1);
        applyStimulus(TICK, 60);
        checkOutput("third alarm suna", int'(suna), 1);
        applyStimulus(L2, 1);
        checkOutput("lung_2 stop suna", int'(suna), 0);
        checkOutput("lung_2 clears al_en", int'(al_en), 0);

        applyStimulus(TICK, 59);
        checkTime("pre freeze", 7, 33, 59);
        applyStimulus(TICK | L1, 1);
        checkTime("lung_1+tick freeze", 7, 33, 0);
        checkOutput("lung_1+tick mod", int'(mod), 1);
        applyStimulus(S1, 3);
        applyStimulus(S2, 1);
        applyStimulus(L1, 1);
        applyStimulus(L2, 1);
        applyStimulus(TICK, 59);
        applyStimulus(TICK | L3, 1);
        checkTime("trigger vs lung_3", 7, 34, 0);
        checkOutput("trigger beats lung_3", int'(suna), 1);

`ifdef CONTROL_SNOOZE_EN
        applyStimulus(TICK, 10);
        applyStimulus(S3, 1);
        checkOutput("snooze stops ring", int'(suna), 0);
        applyStimulus(TICK, 289);
        checkTime("pre snooze", 7, 38, 59);
        checkOutput("pre snooze suna", int'(suna), 0);
        applyStimulus(TICK, 1);
        checkOutput("snooze rings", int'(suna), 1);
`else
        applyStimulus(S3, 1);
        checkOutput("scurt_3 in run ignored", int'(suna), 1);
        checkOutput("scurt_3 mod", int'(mod), 0);
`endif

        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkTime("async reset", 0, 0, 0);
        checkOutput("async reset suna", int'(suna), 0);
        checkOutput("async reset al_en", int'(al_en), 0);
        checkOutput("async reset al_ore", int'(al_ore), 0);
        checkOutput("async reset al_min", int'(al_min), 0);
        checkOutput("async reset mod", int'(mod), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/control_ceas.md
Name: control_ceas

Overview:
- Downstream consumer of the button-press classifier: takes its one-clock short/long press pulses (scurt_1..3, lung_1..3).
- Implements the alarm-clock control core:
  - 24 h timekeeping from a 1 Hz enable.
  - Time/alarm setting mode FSM.
  - Alarm enable, compare and ring timeout.
- Outputs feed the display driver and buzzer.

Parameters:
- RING_SEC, 60, seconds the alarm rings before stopping by itself (1..255).
- SNOOZE_MIN, 5, snooze length in minutes (1..59), used only with the optional feature.

Ports:
- clock     in   1  system clock, all state updates on rising edge
- reset     in   1  asynchronous, active-high; clears all state
- tick_1s   in   1  one-clock enable pulse, once per second
- scurt_1   in   1  short press pulse, button 1 (mode/field)
- scurt_2   in   1  short press pulse, button 2 (increment)
- scurt_3   in   1  short press pulse, button 3 (decrement / snooze)
- lung_1    in   1  long press pulse, button 1 (enter/exit set mode)
- lung_2    in   1  long press pulse, button 2 (toggle alarm enable)
- lung_3    in   1  long press pulse, button 3 (stop alarm)
- ore       out  5  current hours 0..23
- minute    out  6  current minutes 0..59
- secunde   out  6  current seconds 0..59
- al_ore    out  5  alarm hours 0..23
- al_min    out  6  alarm minutes 0..59
- al_en     out  1  alarm armed
- suna      out  1  alarm ringing (buzzer enable)
- mod       out  3  FSM state: 0 RUN, 1 SET_ORA, 2 SET_MIN, 3 SET_AL_ORA, 4 SET_AL_MIN

Behaviour:
- Reset values: all outputs 0; mod=RUN; ring counter 0.
- Input pulses are one clock wide and are sampled on the rising edge. Every action they trigger is visible on outputs 1 clock later.
- Timekeeping on tick_1s:
  - secunde 59->0 carries into minute; minute 59->0 carries into hours; ore 23->0.
  - Counting is paused in SET_ORA and SET_MIN.
  - Counting runs in RUN, SET_AL_ORA and SET_AL_MIN.
- FSM transitions:
  - lung_1 in RUN: go to SET_ORA and clear secunde to 0.
  - lung_1 in any SET state: go to RUN.
  - scurt_1 in a SET state advances the edited field: SET_ORA->SET_MIN->SET_AL_ORA->SET_AL_MIN->SET_ORA.
  - scurt_1 in RUN is ignored.
- Editing, in the field selected by mod:
  - scurt_2 increments with wrap: hours 23->0, minutes 59->0.
  - scurt_3 decrements with wrap: 0->23 / 0->59.
  - Minute edits never carry into hours.
  - scurt_2/scurt_3 in RUN have no edit effect.
- lung_2 toggles al_en in any state. Clearing al_en while ringing also clears suna.
- Alarm trigger:
  - Condition: tick_1s with al_en=1 and, after this tick's increment, ore==al_ore, minute==al_min, secunde==0.
  - Effect: suna=1 and the ring counter loads 0.
  - No trigger while mod is SET_ORA or SET_MIN.
- Ringing:
  - The ring counter increments on each tick_1s.
  - suna clears on the tick that brings the counter to RING_SEC, or on lung_3.
  - al_en is unchanged by either.
- Simultaneous events:
  - tick_1s and an edit pulse in the same cycle: in SET_AL_* both apply; in SET_ORA/SET_MIN ticks are ignored anyway.
  - lung_1 and tick_1s in RUN: the clock does not advance that cycle and secunde=0.
  - lung_3 and a trigger in the same cycle: the trigger wins (suna=1).
  - Several pulses in one cycle: priority lung_1 > lung_2 > lung_3 > scurt_1 > scurt_2 > scurt_3. Lower-priority FSM/edit pulses in that cycle are dropped, except lung_2, which applies in parallel.
- Reset mid-ring or mid-edit: immediate return to reset values. Alarm settings are lost.

Optional Feature:
- CONTROL_SNOOZE_EN defined:
  - scurt_3 while suna=1 and mod=RUN stops ringing.
  - It arms a snooze target = current time + SNOOZE_MIN minutes, with hour/day wrap.
  - The trigger also fires when ore:minute match the snooze target and secunde==0. Firing clears the snooze target.
  - lung_3 or clearing al_en cancels a pending snooze.
- Not defined: scurt_3 in RUN has no effect; no snooze registers are built.

Test Plan:
- Reset, then 3661 tick_1s pulses -> ore=1, minute=1, secunde=1, mod=0, suna=0.
- Preload 23:59:59 via set mode, lung_1 to RUN, 1 tick -> 00:00:00; 59:59 minute edit with scurt_2 -> minute 0, ore unchanged.
- lung_1, scurt_3 in SET_ORA with ore=0 -> ore=23; scurt_1 x4 -> mod cycles 2,3,4,1; ticks in SET_ORA -> secunde stays 0.
- Set alarm 07:30, lung_2 (al_en=1), time 07:29:59, 1 tick -> suna=1; 60 further ticks -> suna=0 on the 60th.
- Ringing, lung_3 -> suna=0 next clock, al_en still 1; lung_2 during ring -> suna=0, al_en=0.
- With CONTROL_SNOOZE_EN: ring at 07:30:00, scurt_3 at 07:30:10 -> suna=0; ticks to 07:35:00 -> suna=1 again. Assert reset mid-ring -> all outputs 0 asynchronously.
